// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arbiter
//  Function : Two-master (CPU / DMA-debug) to one-slave memory arbiter with a
//             grant lock across slave back-pressure and an in-order read-owner
//             FIFO that routes read responses back to the issuing master.
//  Config   : MEM_ARB_ROUND_ROBIN_EN - when defined, contending masters in IDLE
//             alternate; when undefined, master 0 has fixed priority.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic        clk,
    input  logic        reset_,
    // master 0 (CPU)
    input  logic        m0_cmd_valid,
    input  logic        m0_cmd_wr,
    input  logic        m0_cmd_instr,
    input  logic [31:0] m0_cmd_addr,
    input  logic [31:0] m0_cmd_wdata,
    input  logic [3:0]  m0_cmd_be,
    output logic        m0_cmd_ready,
    output logic        m0_rsp_ready,
    output logic [31:0] m0_rsp_rdata,
    // master 1 (DMA / debug)
    input  logic        m1_cmd_valid,
    input  logic        m1_cmd_wr,
    input  logic        m1_cmd_instr,
    input  logic [31:0] m1_cmd_addr,
    input  logic [31:0] m1_cmd_wdata,
    input  logic [3:0]  m1_cmd_be,
    output logic        m1_cmd_ready,
    output logic        m1_rsp_ready,
    output logic [31:0] m1_rsp_rdata,
    // slave
    output logic        slv_cmd_valid,
    output logic        slv_cmd_wr,
    output logic        slv_cmd_instr,
    output logic [31:0] slv_cmd_addr,
    output logic [31:0] slv_cmd_wdata,
    output logic [3:0]  slv_cmd_be,
    input  logic        slv_cmd_ready,
    input  logic        slv_rsp_ready,
    input  logic [31:0] slv_rsp_rdata,
    // status
    output logic        busy,
    output logic        rsp_err
);

    localparam int c_PTR_W = $clog2(MAX_OUTSTANDING);
    localparam int c_CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(MAX_OUTSTANDING);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 r_grant;
    logic                 w_grant;
    logic [c_CNT_W-1:0]   r_count;
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic                 r_owner [MAX_OUTSTANDING];
    logic                 r_rsp_err;

    logic                 w_fwd_valid;
    logic                 w_fwd_wr;
    logic                 w_full;
    logic                 w_accept;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_head;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic                 r_last_grant;

    // Grant select: held while locked, otherwise alternate under contention
    always_comb begin
        w_grant = r_grant;
        if (r_state == IDLE) begin
            if (m0_cmd_valid && m1_cmd_valid) begin
                w_grant = ~r_last_grant;
            end else begin
                w_grant = m1_cmd_valid;
            end
        end
    end

    // Remember who won the most recent accepted command
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            r_last_grant <= 1'b1;
        end else if (w_accept) begin
            r_last_grant <= w_grant;
        end
    end
`else
    // Grant select: held while locked, otherwise master 0 always wins
    always_comb begin
        w_grant = r_grant;
        if (r_state == IDLE) begin
            w_grant = m0_cmd_valid ? 1'b0 : m1_cmd_valid;
        end
    end
`endif

    // Route the granted master's command fields to the slave side
    always_comb begin
        if (w_grant) begin
            w_fwd_valid   = m1_cmd_valid;
            w_fwd_wr      = m1_cmd_wr;
            slv_cmd_instr = m1_cmd_instr;
            slv_cmd_addr  = m1_cmd_addr;
            slv_cmd_wdata = m1_cmd_wdata;
            slv_cmd_be    = m1_cmd_be;
        end else begin
            w_fwd_valid   = m0_cmd_valid;
            w_fwd_wr      = m0_cmd_wr;
            slv_cmd_instr = m0_cmd_instr;
            slv_cmd_addr  = m0_cmd_addr;
            slv_cmd_wdata = m0_cmd_wdata;
            slv_cmd_be    = m0_cmd_be;
        end
    end

    // A read needs a free owner slot; writes never produce a response
    assign w_full        = (r_count == c_FULL);
    assign slv_cmd_wr    = w_fwd_wr;
    assign slv_cmd_valid = reset_ && w_fwd_valid && !(!w_fwd_wr && w_full);
    assign w_accept      = slv_cmd_valid && slv_cmd_ready;
    assign w_push        = w_accept && !w_fwd_wr;
    assign w_pop         = slv_rsp_ready && (r_count != '0);

    assign m0_cmd_ready  = reset_ && !w_grant && slv_cmd_ready && !(!m0_cmd_wr && w_full);
    assign m1_cmd_ready  = reset_ &&  w_grant && slv_cmd_ready && !(!m1_cmd_wr && w_full);

    // Response goes to whoever owns the FIFO head; data is broadcast
    assign w_head        = r_owner[r_rd_ptr];
    assign m0_rsp_ready  = reset_ && w_pop && !w_head;
    assign m1_rsp_ready  = reset_ && w_pop &&  w_head;
    assign m0_rsp_rdata  = slv_rsp_rdata;
    assign m1_rsp_rdata  = slv_rsp_rdata;

    assign busy          = (r_count != '0);
    assign rsp_err       = r_rsp_err;

    // Lock state and grant register
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            r_state <= IDLE;
            r_grant <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant;
        end
    end

    // Lock the grant while the slave stalls an offered command
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (slv_cmd_valid && !slv_cmd_ready) w_state_nxt = LOCKED;
            LOCKED:  if (w_accept)                        w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Owner FIFO bookkeeping; pointers wrap naturally at the power-of-two depth
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            r_count   <= '0;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_rsp_err <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (slv_rsp_ready && (r_count == '0)) r_rsp_err <= 1'b1;
        end
    end

    // Owner storage; contents are only meaningful between the pointers
    always_ff @(posedge clk) begin
        if (w_push) r_owner[r_wr_ptr] <= w_grant;
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_mem_arbiter
//  Function : Self-checking bench for mem_arbiter: directed scenarios with
//             hand-computed expectations plus a randomized run compared every
//             cycle against a queue-based reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int MAXO = 4;

    logic        clk = 1'b0;
    logic        reset_;
    logic [1:0]  m_valid, m_wr, m_instr;
    logic [31:0] m_addr  [2];
    logic [31:0] m_wdata [2];
    logic [3:0]  m_be    [2];
    logic [1:0]  m_cmd_ready, m_rsp_ready;
    logic [31:0] m_rdata [2];
    logic        slv_cmd_valid, slv_cmd_wr, slv_cmd_instr;
    logic [31:0] slv_cmd_addr, slv_cmd_wdata;
    logic [3:0]  slv_cmd_be;
    logic        slv_cmd_ready, slv_rsp_ready;
    logic [31:0] slv_rsp_rdata;
    logic        busy, rsp_err;

    int checks = 0;
    int errors = 0;

    // reference model state
    int q[$];
    bit mlocked;
    int mheld;
    int mlast;
    bit merr;

    always #5 clk = ~clk;

    mem_arbiter #(.MAX_OUTSTANDING(MAXO)) dut (
        .clk(clk), .reset_(reset_),
        .m0_cmd_valid(m_valid[0]), .m0_cmd_wr(m_wr[0]), .m0_cmd_instr(m_instr[0]),
        .m0_cmd_addr(m_addr[0]), .m0_cmd_wdata(m_wdata[0]), .m0_cmd_be(m_be[0]),
        .m0_cmd_ready(m_cmd_ready[0]), .m0_rsp_ready(m_rsp_ready[0]), .m0_rsp_rdata(m_rdata[0]),
        .m1_cmd_valid(m_valid[1]), .m1_cmd_wr(m_wr[1]), .m1_cmd_instr(m_instr[1]),
        .m1_cmd_addr(m_addr[1]), .m1_cmd_wdata(m_wdata[1]), .m1_cmd_be(m_be[1]),
        .m1_cmd_ready(m_cmd_ready[1]), .m1_rsp_ready(m_rsp_ready[1]), .m1_rsp_rdata(m_rdata[1]),
        .slv_cmd_valid(slv_cmd_valid), .slv_cmd_wr(slv_cmd_wr), .slv_cmd_instr(slv_cmd_instr),
        .slv_cmd_addr(slv_cmd_addr), .slv_cmd_wdata(slv_cmd_wdata), .slv_cmd_be(slv_cmd_be),
        .slv_cmd_ready(slv_cmd_ready), .slv_rsp_ready(slv_rsp_ready), .slv_rsp_rdata(slv_rsp_rdata),
        .busy(busy), .rsp_err(rsp_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Arbitration rule: locked grant wins; otherwise policy decides contention
    function automatic int model_grant();
        if (mlocked) return mheld;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        if (m_valid[0] && m_valid[1]) return 1 - mlast;
`else
        if (m_valid[0] && m_valid[1]) return 0;
`endif
        return m_valid[1] ? 1 : 0;
    endfunction

    // Compare DUT against the model each cycle, then advance the model
    always @(negedge clk) begin
        int  g;
        bit  full, ev, acc, er;
        if (!reset_) begin
            q.delete();
            mlocked = 0; mheld = 0; mlast = 1; merr = 0;
            chk("rst_slv_valid", slv_cmd_valid, 0);
            chk("rst_rsp_ready", m_rsp_ready, 0);
            chk("rst_busy", busy, 0);
            chk("rst_err", rsp_err, 0);
        end else begin
            g    = model_grant();
            full = (q.size() == MAXO);
            ev   = m_valid[g] && !(!m_wr[g] && full);
            chk("m_slv_valid", slv_cmd_valid, ev);
            if (ev) begin
                chk("m_slv_wr", slv_cmd_wr, m_wr[g]);
                chk("m_slv_instr", slv_cmd_instr, m_instr[g]);
                chk("m_slv_addr", slv_cmd_addr, m_addr[g]);
                chk("m_slv_wdata", slv_cmd_wdata, m_wdata[g]);
                chk("m_slv_be", slv_cmd_be, m_be[g]);
            end
            if (mlocked || m_valid != 2'b00) begin
                for (int n = 0; n < 2; n++) begin
                    er = (g == n) && slv_cmd_ready && !(!m_wr[n] && full);
                    chk($sformatf("m_cmd_ready%0d", n), m_cmd_ready[n], er);
                end
            end
            for (int n = 0; n < 2; n++) begin
                er = slv_rsp_ready && (q.size() > 0) && (q[0] == n);
                chk($sformatf("m_rsp_ready%0d", n), m_rsp_ready[n], er);
                chk($sformatf("m_rdata%0d", n), m_rdata[n], slv_rsp_rdata);
            end
            chk("m_busy", busy, q.size() != 0);
            chk("m_err", rsp_err, merr);
            acc = ev && slv_cmd_ready;
            if (slv_rsp_ready) begin
                if (q.size() > 0) void'(q.pop_front());
                else merr = 1;
            end
            if (acc && !m_wr[g]) q.push_back(g);
            if (acc) mlast = g;
            if (!mlocked && ev && !slv_cmd_ready) begin
                mlocked = 1; mheld = g;
            end else if (mlocked && acc) begin
                mlocked = 0;
            end
        end
    end

    task automatic idle_inputs();
        m_valid = 2'b00; m_wr = 2'b00; m_instr = 2'b00;
        for (int n = 0; n < 2; n++) begin
            m_addr[n] = 32'h0; m_wdata[n] = 32'h0; m_be[n] = 4'h0;
        end
        slv_cmd_ready = 1'b1; slv_rsp_ready = 1'b0; slv_rsp_rdata = $urandom;
    endtask

    task automatic set_m(input int n, input logic wr, input logic [31:0] addr);
        m_valid[n] = 1'b1; m_wr[n] = wr; m_instr[n] = 1'b0;
        m_addr[n] = addr; m_wdata[n] = addr ^ 32'h5A5A_0000; m_be[n] = 4'hF;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic do_reset();
        reset_ = 1'b0;
        idle_inputs();
        settle();
        chk("reset_busy", busy, 0);
        chk("reset_err", rsp_err, 0);
        chk("reset_slv_valid", slv_cmd_valid, 0);
        repeat (2) @(posedge clk);
        #1 reset_ = 1'b1;
    endtask

    int owners [4];

    initial begin
        reset_ = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1 reset_ = 1'b1;

        // single m0 read, response two cycles after issue
        set_m(0, 1'b0, 32'h100); settle();
        chk("d1_slv_valid", slv_cmd_valid, 1);
        chk("d1_slv_addr", slv_cmd_addr, 32'h100);
        chk("d1_cmd_ready", m_cmd_ready, 2'b01);
        tick(); idle_inputs(); settle();
        chk("d1_busy_hi", busy, 1);
        tick(); slv_rsp_ready = 1'b1; slv_rsp_rdata = 32'hCAFE_0100; settle();
        chk("d1_rsp_ready", m_rsp_ready, 2'b01);
        chk("d1_rdata", m_rdata[0], 32'hCAFE_0100);
        tick(); idle_inputs(); settle();
        chk("d1_busy_lo", busy, 0);
        chk("d1_rsp_off", m_rsp_ready, 2'b00);
        chk("d1_err", rsp_err, 0);
        tick();

        // continuous contention for eight cycles
        do_reset();
        for (int i = 0; i < 9; i++) begin
            idle_inputs();
            if (i < 8) begin
                set_m(0, 1'b0, 32'h1000 + i);
                set_m(1, 1'b0, 32'h2000 + i);
            end
            slv_rsp_ready = (i >= 1);
            settle();
            if (i < 8) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
                chk($sformatf("d2_grant%0d", i), m_cmd_ready, (i % 2 == 0) ? 2'b01 : 2'b10);
`else
                chk($sformatf("d2_grant%0d", i), m_cmd_ready, 2'b01);
`endif
            end
            tick();
        end
        idle_inputs(); settle();
        chk("d2_busy", busy, 0);
        chk("d2_err", rsp_err, 0);
        tick();

        // m1 write stalled three cycles while m0 waits
        do_reset();
        for (int i = 0; i < 6; i++) begin
            idle_inputs();
            if (i < 4) set_m(1, 1'b1, 32'h200);
            if (i >= 1 && i < 5) set_m(0, 1'b0, 32'h300);
            slv_cmd_ready = (i >= 3);
            slv_rsp_ready = (i == 5);
            settle();
            case (i)
                0, 1, 2: begin
                    chk($sformatf("d3_stall_ready%0d", i), m_cmd_ready, 2'b00);
                    chk($sformatf("d3_stall_addr%0d", i), slv_cmd_addr, 32'h200);
                end
                3: chk("d3_accept1", m_cmd_ready, 2'b10);
                4: begin
                    chk("d3_accept0", m_cmd_ready, 2'b01);
                    chk("d3_addr0", slv_cmd_addr, 32'h300);
                end
                default: chk("d3_rsp0", m_rsp_ready, 2'b01);
            endcase
            tick();
        end

        // fill the owner FIFO, then probe the full boundary
        do_reset();
        for (int i = 0; i < 4; i++) begin
            idle_inputs(); set_m(0, 1'b0, 32'h400 + 4 * i); settle();
            chk($sformatf("d4_fill%0d", i), m_cmd_ready[0], 1);
            tick();
        end
        idle_inputs(); set_m(0, 1'b0, 32'h410); settle();
        chk("d4_full_valid", slv_cmd_valid, 0);
        chk("d4_full_ready", m_cmd_ready[0], 0);
        tick();
        idle_inputs(); set_m(0, 1'b1, 32'h414); settle();
        chk("d4_wr_valid", slv_cmd_valid, 1);
        chk("d4_wr_ready", m_cmd_ready[0], 1);
        tick();
        idle_inputs(); set_m(0, 1'b0, 32'h418); slv_rsp_ready = 1'b1; settle();
        chk("d4_popfull_valid", slv_cmd_valid, 0);
        chk("d4_popfull_rsp", m_rsp_ready, 2'b01);
        tick();
        idle_inputs(); set_m(0, 1'b0, 32'h418); settle();
        chk("d4_freed_ready", m_cmd_ready[0], 1);
        tick();
        for (int i = 0; i < 4; i++) begin
            idle_inputs(); slv_rsp_ready = 1'b1; tick();
        end
        idle_inputs(); settle();
        chk("d4_drained", busy, 0);
        tick();

        // interleaved owners return in order
        do_reset();
        owners = '{0, 1, 1, 0};
        for (int i = 0; i < 4; i++) begin
            idle_inputs(); set_m(owners[i], 1'b0, 32'h500 + i); tick();
        end
        for (int i = 0; i < 4; i++) begin
            idle_inputs(); slv_rsp_ready = 1'b1; slv_rsp_rdata = 32'hD0 + i; settle();
            chk($sformatf("d5_owner%0d", i), m_rsp_ready, (owners[i] == 1) ? 2'b10 : 2'b01);
            chk($sformatf("d5_data%0d", i), m_rdata[owners[i]], 32'hD0 + i);
            tick();
        end

        // response with nothing outstanding
        do_reset();
        idle_inputs(); slv_rsp_ready = 1'b1; settle();
        chk("d6_no_rsp", m_rsp_ready, 2'b00);
        tick(); idle_inputs(); settle();
        chk("d6_err_set", rsp_err, 1);
        chk("d6_busy", busy, 0);
        repeat (3) tick();
        settle();
        chk("d6_err_held", rsp_err, 1);
        tick();
        do_reset();
        settle();
        chk("d6_err_clear", rsp_err, 0);
        tick();

        // randomized traffic with one mid-run reset
        for (int i = 0; i < 1500; i++) begin
            for (int n = 0; n < 2; n++) begin
                m_valid[n] = ($urandom_range(0, 9) < 6);
                m_wr[n]    = ($urandom_range(0, 9) < 4);
                m_instr[n] = 1'($urandom_range(0, 1));
                m_addr[n]  = $urandom;
                m_wdata[n] = $urandom;
                m_be[n]    = 4'($urandom_range(0, 15));
            end
            slv_cmd_ready = ($urandom_range(0, 9) < 7);
            slv_rsp_ready = (q.size() > 0) ? ($urandom_range(0, 9) < 3)
                                           : ($urandom_range(0, 99) < 2);
            slv_rsp_rdata = $urandom;
            if (i == 700) reset_ = 1'b0;
            if (i == 702) reset_ = 1'b1;
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
